// File: rtl/pic_gpio_bank.sv
// PIC-style GPIO bank: per-port TRIS and output latches, pin synchronizers,
// and optional sticky change-on-input flags with an irq (macro GPIO_CHANGE_DETECT_EN).
module pic_gpio_bank #(
  parameter int NUM_PORTS   = 3,
  parameter int PORT_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [2:0]                      portSel,
  input  logic                            trisWe,
  input  logic                            latWe,
  input  logic [PORT_WIDTH-1:0]           wrData,
  input  logic                            ackChange,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] pinIn,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pinOut,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] trisOut,
  output logic [PORT_WIDTH-1:0]           rdData,
  output logic [PORT_WIDTH-1:0]           latData,
  output logic [NUM_PORTS-1:0]            chgFlags,
  output logic                            irq
);

  localparam int BUS = NUM_PORTS * PORT_WIDTH;
  localparam logic [3:0] NP = 4'(NUM_PORTS);

  logic [BUS-1:0] tris_q, tris_d;
  logic [BUS-1:0] lat_q, lat_d;
  logic [BUS-1:0] sync_q [SYNC_STAGES];
  logic [BUS-1:0] pin_s;
  logic           sel_ok;

  assign sel_ok  = ({1'b0, portSel} < NP);
  assign pin_s   = sync_q[SYNC_STAGES-1];
  assign pinOut  = lat_q;
  assign trisOut = tris_q;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    tris_d  = tris_q;
    lat_d   = lat_q;
    rdData  = '0;
    latData = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_ok && portSel == 3'(p)) begin
        if (trisWe) tris_d[p*PORT_WIDTH +: PORT_WIDTH] = wrData;
        if (latWe)  lat_d[p*PORT_WIDTH +: PORT_WIDTH]  = wrData;
        rdData  = pin_s[p*PORT_WIDTH +: PORT_WIDTH];
        latData = lat_q[p*PORT_WIDTH +: PORT_WIDTH];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the sync "array" is plain flops, not RAM, so resetting it is legal and cheap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tris_q <= '1;
      lat_q  <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      tris_q    <= tris_d;
      lat_q     <= lat_d;
      sync_q[0] <= pinIn;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef GPIO_CHANGE_DETECT_EN
  localparam int AW = $clog2(SYNC_STAGES + 1);

  logic [AW-1:0]        arm_q, arm_d;
  logic                 armed;
  logic [BUS-1:0]       snap_q;
  logic [NUM_PORTS-1:0] flags_q, flags_d;

  assign armed = (arm_q == AW'(SYNC_STAGES));

  // A fresh detection is applied after the acknowledge so it wins on the same port.
  always_comb begin
    arm_d   = armed ? arm_q : arm_q + AW'(1);
    flags_d = flags_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_ok && ackChange && portSel == 3'(p)) flags_d[p] = 1'b0;
      if (armed && |((pin_s[p*PORT_WIDTH +: PORT_WIDTH] ^ snap_q[p*PORT_WIDTH +: PORT_WIDTH])
                     & tris_q[p*PORT_WIDTH +: PORT_WIDTH]))
        flags_d[p] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arm_q   <= '0;
      snap_q  <= '0;
      flags_q <= '0;
    end else begin
      arm_q   <= arm_d;
      snap_q  <= pin_s;
      flags_q <= flags_d;
    end
  end

  assign chgFlags = flags_q;
  assign irq      = |flags_q;
`else
  logic unused_ack;
  assign unused_ack = ackChange;
  assign chgFlags   = '0;
  assign irq        = 1'b0;
`endif

endmodule
